// File: rtl/pipe_seq_pkg.sv
// Shared types and constants for the pipeline sequencer.
package pipe_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRun,
    StDrain,
    StHalted
  } ps_state_e;

  localparam logic [5:0]  OP_RTYPE        = 6'h00;
  localparam logic [5:0]  HALT_OP_DEFAULT = 6'h3F;
  localparam logic [31:0] NOP_INSTR       = 32'h0000_0000;

  // Only R-type instructions with a non-zero destination update the register bank.
  function automatic logic writes_reg(logic [5:0] op, logic [4:0] rd);
    return (op == OP_RTYPE) && (rd != 5'd0);
  endfunction

endpackage

// File: rtl/pipe_seq_hazard.sv
// Read-after-write comparator: decode sources against the destination held in EX.
module pipe_seq_hazard (
  input  logic       v_de,
  input  logic       v_ex,
  input  logic       wr_ex,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic [4:0] rd_ex,
  output logic       hazard
);

  assign hazard = v_de & v_ex & wr_ex & (rd_ex != 5'd0) & ((rs == rd_ex) | (rt == rd_ex));

endmodule

// File: rtl/pipe_seq.sv
// Boot/run/drain/halt sequencer for the PC -> BF0 -> BF1 -> BF2 datapath.
// Define PS_HAZARD_EN to enable read-after-write stall insertion.
module pipe_seq
  import pipe_seq_pkg::*;
#(
  parameter logic [5:0]  HALT_OP = HALT_OP_DEFAULT,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk_PS,
  input  logic             rst_n_PS,
  input  logic             start_PS,
  input  logic             abort_PS,
  input  logic [5:0]       op_PS,
  input  logic [4:0]       rs_PS,
  input  logic [4:0]       rt_PS,
  input  logic [4:0]       rd_PS,
  output logic             pcLoad_PS,
  output logic             pcEn_PS,
  output logic             bf0En_PS,
  output logic             bf1En_PS,
  output logic             bf1Bubble_PS,
  output logic             bf2En_PS,
  output logic             regWriteFlag_PS,
  output logic             busy_PS,
  output logic             halted_PS,
  output logic [CNT_W-1:0] retired_PS
);

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  ps_state_e        state_q, state_d;
  logic             v_de_q, v_de_d;
  logic             v_ex_q, v_ex_d;
  logic             v_wb_q, v_wb_d;
  logic             wr_ex_q, wr_ex_d;
  logic [4:0]       rd_ex_q, rd_ex_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic hazard;
  logic halt_dec;

`ifdef PS_HAZARD_EN
  pipe_seq_hazard u_hazard (
    .v_de   (v_de_q),
    .v_ex   (v_ex_q),
    .wr_ex  (wr_ex_q),
    .rs     (rs_PS),
    .rt     (rt_PS),
    .rd_ex  (rd_ex_q),
    .hazard (hazard)
  );
`else
  logic unused_hazard_inputs;
  assign hazard               = 1'b0;
  assign unused_hazard_inputs = ^{rs_PS, rt_PS, rd_ex_q};
`endif

  assign halt_dec = (state_q == StRun) & v_de_q & (op_PS == HALT_OP);

  // State register
  always_ff @(posedge clk_PS or negedge rst_n_PS) begin
    if (!rst_n_PS) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort overrides everything
  always_comb begin
    state_d = state_q;
    if (abort_PS) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:   if (start_PS) state_d = StLoad;
        StLoad:   state_d = StRun;
        StRun:    if (halt_dec) state_d = StDrain;
        StDrain:  if (!v_ex_q && !v_wb_q) state_d = StHalted;
        StHalted: if (start_PS) state_d = StLoad;
        default:  state_d = StIdle;
      endcase
    end
  end

  // Outputs depend only on state and pipeline valids
  always_comb begin
    pcLoad_PS    = 1'b0;
    pcEn_PS      = 1'b0;
    bf0En_PS     = 1'b0;
    bf1En_PS     = 1'b0;
    bf1Bubble_PS = 1'b0;
    bf2En_PS     = 1'b0;
    unique case (state_q)
      StLoad: begin
        pcLoad_PS = 1'b1;
        pcEn_PS   = 1'b1;
      end
      StRun: begin
        bf1En_PS = 1'b1;
        bf2En_PS = 1'b1;
        if (halt_dec || hazard) begin
          bf1Bubble_PS = 1'b1;
        end else begin
          pcEn_PS  = 1'b1;
          bf0En_PS = 1'b1;
        end
      end
      StDrain: begin
        bf1En_PS     = 1'b1;
        bf1Bubble_PS = 1'b1;
        bf2En_PS     = 1'b1;
      end
      default: ;
    endcase
    regWriteFlag_PS = v_ex_q & wr_ex_q & ((state_q == StRun) | (state_q == StDrain));
    busy_PS         = (state_q == StLoad) | (state_q == StRun) | (state_q == StDrain);
    halted_PS       = (state_q == StHalted);
  end

  assign retired_PS = retired_q;

  // Pipeline tracking; a bubble is simply a slot whose valid bit is clear
  always_comb begin
    v_de_d    = v_de_q;
    v_ex_d    = v_ex_q;
    v_wb_d    = v_wb_q;
    wr_ex_d   = wr_ex_q;
    rd_ex_d   = rd_ex_q;
    retired_d = retired_q;

    if (v_wb_q && (retired_q != {CNT_W{1'b1}})) begin
      retired_d = retired_q + CntOne;
    end

    if (abort_PS) begin
      v_de_d  = 1'b0;
      v_ex_d  = 1'b0;
      v_wb_d  = 1'b0;
      wr_ex_d = 1'b0;
    end else begin
      unique case (state_q)
        StLoad: begin
          v_de_d    = 1'b0;
          v_ex_d    = 1'b0;
          v_wb_d    = 1'b0;
          wr_ex_d   = 1'b0;
          retired_d = '0;
        end
        StRun: begin
          v_wb_d = v_ex_q;
          if (halt_dec || hazard) begin
            v_de_d  = ~halt_dec & v_de_q;
            v_ex_d  = 1'b0;
            wr_ex_d = 1'b0;
          end else begin
            v_de_d  = 1'b1;
            v_ex_d  = v_de_q;
            wr_ex_d = v_de_q & writes_reg(op_PS, rd_PS);
            rd_ex_d = rd_PS;
          end
        end
        StDrain: begin
          v_ex_d  = 1'b0;
          wr_ex_d = 1'b0;
          v_wb_d  = v_ex_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_PS or negedge rst_n_PS) begin
    if (!rst_n_PS) begin
      v_de_q    <= 1'b0;
      v_ex_q    <= 1'b0;
      v_wb_q    <= 1'b0;
      wr_ex_q   <= 1'b0;
      rd_ex_q   <= 5'd0;
      retired_q <= '0;
    end else begin
      v_de_q    <= v_de_d;
      v_ex_q    <= v_ex_d;
      v_wb_q    <= v_wb_d;
      wr_ex_q   <= wr_ex_d;
      rd_ex_q   <= rd_ex_d;
      retired_q <= retired_d;
    end
  end

endmodule

// File: tb/tb_pipe_seq.sv
// Directed bench for pipe_seq with a small PC/BF0 datapath model feeding the decode fields.
module tb_pipe_seq;

  typedef struct packed {
    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
  } instr_t;

  // Vector bits: pcLoad pcEn bf0En bf1En bf1Bubble bf2En regWrite busy halted
  localparam logic [8:0] E_IDLE   = 9'b000000000;
  localparam logic [8:0] E_LOAD   = 9'b110000010;
  localparam logic [8:0] E_RUN    = 9'b011101010;
  localparam logic [8:0] E_RUNW   = 9'b011101110;
  localparam logic [8:0] E_BUB    = 9'b000111010;
  localparam logic [8:0] E_BUBW   = 9'b000111110;
  localparam logic [8:0] E_HALTED = 9'b000000001;
  localparam logic [5:0] HALT     = 6'h3F;

  logic clk = 1'b0;
  logic rst_n, start, abort;
  logic [5:0] op;
  logic [4:0] rs, rt, rd;

  logic pc_load, pc_en, bf0_en, bf1_en, bub, bf2_en, rw, busy, halted;
  logic [15:0] retired;
  logic s_pc_load, s_pc_en, s_bf0_en, s_bf1_en, s_bub, s_bf2_en, s_rw, s_busy, s_halted;
  logic [1:0] s_retired;
  logic [8:0] vec, sat_vec;

  instr_t     imem [16];
  logic [3:0] pc;
  instr_t     bf0;

  int checks = 0;
  int failures = 0;
  logic [8:0] exp_q [$];

  always #5 clk = ~clk;

  pipe_seq dut (
    .clk_PS(clk), .rst_n_PS(rst_n), .start_PS(start), .abort_PS(abort),
    .op_PS(op), .rs_PS(rs), .rt_PS(rt), .rd_PS(rd),
    .pcLoad_PS(pc_load), .pcEn_PS(pc_en), .bf0En_PS(bf0_en), .bf1En_PS(bf1_en),
    .bf1Bubble_PS(bub), .bf2En_PS(bf2_en), .regWriteFlag_PS(rw), .busy_PS(busy),
    .halted_PS(halted), .retired_PS(retired)
  );

  // Narrow counter instance exercises saturation with the same stimulus
  pipe_seq #(.CNT_W(2)) u_sat (
    .clk_PS(clk), .rst_n_PS(rst_n), .start_PS(start), .abort_PS(abort),
    .op_PS(op), .rs_PS(rs), .rt_PS(rt), .rd_PS(rd),
    .pcLoad_PS(s_pc_load), .pcEn_PS(s_pc_en), .bf0En_PS(s_bf0_en), .bf1En_PS(s_bf1_en),
    .bf1Bubble_PS(s_bub), .bf2En_PS(s_bf2_en), .regWriteFlag_PS(s_rw), .busy_PS(s_busy),
    .halted_PS(s_halted), .retired_PS(s_retired)
  );

  assign vec     = {pc_load, pc_en, bf0_en, bf1_en, bub, bf2_en, rw, busy, halted};
  assign sat_vec = {s_pc_load, s_pc_en, s_bf0_en, s_bf1_en, s_bub, s_bf2_en, s_rw, s_busy,
                    s_halted};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc  <= 4'd0;
      bf0 <= '0;
    end else begin
      if (pc_en) pc <= pc_load ? 4'd0 : pc + 4'd1;
      if (bf0_en) bf0 <= imem[pc];
    end
  end

  assign op = bf0.op;
  assign rs = bf0.rs;
  assign rt = bf0.rt;
  assign rd = bf0.rd;

  task automatic chk_vec(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_ret(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle, queue its expected outputs, compare before the next rising edge
  task automatic cyc(input logic st, input logic ab, input logic [8:0] e, input string tag);
    logic [8:0] want;
    start = st;
    abort = ab;
    exp_q.push_back(e);
    @(negedge clk);
    want = exp_q.pop_front();
    chk_vec(tag, vec, want);
    chk_vec({tag, "_sat"}, sat_vec, want);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < 16; i++) imem[i] = '0;
    #2 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_vec("reset_out", vec, E_IDLE);
    chk_ret("reset_ret", retired, 16'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Four independent R-type instructions then HALT
    imem[0] = '{op: 6'h00, rs: 5'd1, rt: 5'd2, rd: 5'd10};
    imem[1] = '{op: 6'h00, rs: 5'd1, rt: 5'd2, rd: 5'd11};
    imem[2] = '{op: 6'h00, rs: 5'd1, rt: 5'd2, rd: 5'd12};
    imem[3] = '{op: 6'h00, rs: 5'd1, rt: 5'd2, rd: 5'd13};
    imem[4] = '{op: HALT, rs: 5'd0, rt: 5'd0, rd: 5'd0};
    cyc(1'b1, 1'b0, E_IDLE, "a_start");
    cyc(1'b0, 1'b0, E_LOAD, "a_load");
    cyc(1'b0, 1'b0, E_RUN, "a_fetch");
    cyc(1'b0, 1'b0, E_RUN, "a_dec0");
    cyc(1'b0, 1'b0, E_RUNW, "a_ex0");
    cyc(1'b0, 1'b0, E_RUNW, "a_ex1");
    cyc(1'b0, 1'b0, E_RUNW, "a_ex2");
    cyc(1'b0, 1'b0, E_BUBW, "a_halt_dec");
    cyc(1'b0, 1'b0, E_BUB, "a_drain0");
    cyc(1'b0, 1'b0, E_BUB, "a_drain1");
    cyc(1'b0, 1'b0, E_HALTED, "a_halted");
    chk_ret("a_retired", retired, 16'd4);
    chk_ret("a_sat_retired", {14'd0, s_retired}, 16'd3);
    cyc(1'b0, 1'b0, E_HALTED, "a_hold");

    // Restart from HALTED, then reset in the middle of RUN
    cyc(1'b1, 1'b0, E_HALTED, "r_start");
    cyc(1'b0, 1'b0, E_LOAD, "r_load");
    chk_ret("r_ret_cleared", retired, 16'd0);
    cyc(1'b0, 1'b0, E_RUN, "r_fetch");
    cyc(1'b0, 1'b0, E_RUN, "r_dec0");
    rst_n = 1'b0;
    #1;
    chk_vec("rst_mid_out", vec, E_IDLE);
    chk_vec("rst_mid_out_sat", sat_vec, E_IDLE);
    chk_ret("rst_mid_ret", retired, 16'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(1'b0, 1'b0, E_IDLE, "post_rst_idle");

    // add $3,$1,$2 ; sub $4,$3,$1 ; HALT
    imem[0] = '{op: 6'h00, rs: 5'd1, rt: 5'd2, rd: 5'd3};
    imem[1] = '{op: 6'h00, rs: 5'd3, rt: 5'd1, rd: 5'd4};
    imem[2] = '{op: HALT, rs: 5'd0, rt: 5'd0, rd: 5'd0};
    cyc(1'b1, 1'b0, E_IDLE, "b_start");
    cyc(1'b0, 1'b0, E_LOAD, "b_load");
    cyc(1'b0, 1'b0, E_RUN, "b_fetch");
    cyc(1'b0, 1'b0, E_RUN, "b_dec0");
`ifdef PS_HAZARD_EN
    cyc(1'b0, 1'b0, E_BUBW, "b_stall");
    cyc(1'b0, 1'b0, E_RUN, "b_dec1");
`else
    cyc(1'b0, 1'b0, E_RUNW, "b_dec1");
`endif
    cyc(1'b0, 1'b0, E_BUBW, "b_halt_dec");
    cyc(1'b0, 1'b0, E_BUB, "b_drain0");
    cyc(1'b0, 1'b0, E_BUB, "b_drain1");
    cyc(1'b0, 1'b0, E_HALTED, "b_halted");
    chk_ret("b_retired", retired, 16'd2);

    // rd=0 writer then reader of $0; start pulse during RUN is ignored
    imem[0] = '{op: 6'h00, rs: 5'd1, rt: 5'd2, rd: 5'd0};
    imem[1] = '{op: 6'h00, rs: 5'd0, rt: 5'd0, rd: 5'd5};
    imem[2] = '{op: HALT, rs: 5'd0, rt: 5'd0, rd: 5'd0};
    cyc(1'b1, 1'b0, E_HALTED, "c_start");
    cyc(1'b0, 1'b0, E_LOAD, "c_load");
    cyc(1'b0, 1'b0, E_RUN, "c_fetch");
    cyc(1'b1, 1'b0, E_RUN, "c_dec0_start_ignored");
    cyc(1'b0, 1'b0, E_RUN, "c_rd0_in_ex");
    cyc(1'b0, 1'b0, E_BUBW, "c_halt_dec");
    cyc(1'b0, 1'b0, E_BUB, "c_drain0");
    cyc(1'b0, 1'b0, E_BUB, "c_drain1");
    cyc(1'b0, 1'b0, E_HALTED, "c_halted");
    chk_ret("c_retired", retired, 16'd2);
    chk_ret("c_sat_retired", {14'd0, s_retired}, 16'd2);

    // abort in the same cycle HALT is decoded
    imem[0] = '{op: 6'h00, rs: 5'd1, rt: 5'd2, rd: 5'd9};
    imem[1] = '{op: HALT, rs: 5'd0, rt: 5'd0, rd: 5'd0};
    cyc(1'b1, 1'b0, E_HALTED, "d_start");
    cyc(1'b0, 1'b0, E_LOAD, "d_load");
    cyc(1'b0, 1'b0, E_RUN, "d_fetch");
    cyc(1'b0, 1'b0, E_RUN, "d_dec0");
    cyc(1'b0, 1'b1, E_BUBW, "d_halt_abort");
    cyc(1'b0, 1'b0, E_IDLE, "d_idle");
    cyc(1'b0, 1'b0, E_IDLE, "d_idle_hold");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
